// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch unit: FSM state encoding and next-PC select codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pcsrc_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_increment.sv
// Sequential-PC adder: produces PC + 4.
// Latency: combinational.
// Backpressure: none.
module pc_increment
    import pc_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4
);

    assign pc4 = pc + XLEN'(4);

endmodule

// File: rtl/pc_fetch.sv
// PC register, next-PC select and single-outstanding instruction fetch (IDLE/REQ/DONE).
// Latency: start edge -> REQ; IR and ir_valid appear one edge after imem_ready seen in REQ.
// Backpressure: REQ waits indefinitely for imem_ready; start/PCWre outside IDLE are dropped.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            PCWre,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [25:0]     jaddr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC4,
    output logic [XLEN-1:0] IR,
    output logic            ir_valid,
    output logic            busy,
    output logic            addr_err
);

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            pc_load;
    logic            jr_misaligned;

    pc_increment u_pc_increment (
        .pc  (PC),
        .pc4 (PC4)
    );

    always_comb begin
        pc_nxt = PC4;
        case (pcsrc_t'(PCSrc))
            PC_INC:  pc_nxt = PC4;
            PC_BR:   pc_nxt = PC4 + (imm_ext << 2);
            PC_J:    pc_nxt = {PC4[31:28], jaddr, 2'b00};
            PC_JR:   pc_nxt = word_align(rs_data);
            default: pc_nxt = PC4;
        endcase
    end

    // PC only moves between fetches so the address stays stable while REQ is open.
    assign pc_load       = (state == IDLE) && PCWre;
    assign jr_misaligned = pc_load && (PCSrc == PC_JR) && (rs_data[1:0] != 2'b00);
    assign imem_addr     = PC;

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        busy      = 1'b0;
        ir_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ready) state_nxt = DONE;
            end
            DONE: begin
                ir_valid  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            PC       <= RESET_PC;
            IR       <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_err <= jr_misaligned;
            if (pc_load) PC <= pc_nxt;
            if ((state == REQ) && imem_ready) IR <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized scoreboard bench for pc_fetch against a transaction-level PC/fetch model.
module tb_pc_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext;
    logic [25:0] jaddr;
    logic [31:0] rs_data;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic [31:0] IR;
    logic        ir_valid;
    logic        busy;
    logic        addr_err;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .imm_ext    (imm_ext),
        .jaddr      (jaddr),
        .rs_data    (rs_data),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .PC         (PC),
        .PC4        (PC4),
        .IR         (IR),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ir;
    } fetch_t;

    fetch_t      exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    bit          m_busy;
    bit          m_irv;
    bit          m_err;
    bit          live = 1'b0;
    int          total = 0;
    int          bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_evt(input string name);
        total++;
        bad++;
        if (bad <= 40) $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
    endfunction

    // Architectural next-PC rule in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [25:0] ja,
                                             input logic [31:0] rs);
        logic [31:0] seq;
        seq = pc + 32'd4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + imm * 32'd4;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
            default: return rs - (rs % 32'd4);
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        m_err = 1'b0;
        m_irv = 1'b0;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        start      = 1'($urandom);
        PCWre      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        RST        = 1'b0;
        start      = 1'b0;
        PCWre      = 1'b0;
        imem_ready = 1'b0;
        m_pc       = RST_PC;
        m_ir       = 32'd0;
        m_busy     = 1'b0;
        m_irv      = 1'b0;
        m_err      = 1'b0;
        exp_q.delete();
    endtask

    task automatic commit(input logic [1:0] src, input logic [31:0] imm,
                          input logic [25:0] ja, input logic [31:0] rs);
        logic [31:0] nxt;
        PCSrc   = src;
        imm_ext = imm;
        jaddr   = ja;
        rs_data = rs;
        PCWre   = 1'b1;
        nxt     = ref_next(m_pc, src, imm, ja, rs);
        tick();
        PCWre = 1'b0;
        m_pc  = nxt;
        m_err = (src == 2'd3) && (rs % 32'd4 != 0);
    endtask

    task automatic fetch(input logic [31:0] rdata, input int waits,
                         input bit with_commit, input bit rst_mid);
        logic [31:0] nxt;
        bit          err;
        nxt   = m_pc;
        err   = 1'b0;
        start = 1'b1;
        if (with_commit) begin
            PCSrc   = 2'($urandom);
            imm_ext = $urandom;
            jaddr   = 26'($urandom);
            rs_data = $urandom;
            PCWre   = 1'b1;
            nxt     = ref_next(m_pc, PCSrc, imm_ext, jaddr, rs_data);
            err     = (PCSrc == 2'd3) && (rs_data % 32'd4 != 0);
        end
        tick();
        start      = 1'b0;
        PCWre      = 1'b0;
        imem_ready = 1'b0;
        m_pc       = nxt;
        m_err      = err;
        m_busy     = 1'b1;
        exp_q.push_back('{addr: m_pc, ir: rdata});
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            start      = (i == 1) ? 1'b1 : 1'($urandom);
            PCWre      = (i == 2) ? 1'b1 : 1'($urandom);
            PCSrc      = 2'($urandom);
            imm_ext    = $urandom;
            rs_data    = $urandom;
            imem_rdata = $urandom;
            tick();
        end
        if (rst_mid) begin
            do_reset();
            return;
        end
        start      = 1'($urandom);
        PCWre      = 1'($urandom);
        imem_ready = 1'b1;
        imem_rdata = rdata;
        tick();
        m_busy     = 1'b0;
        m_irv      = 1'b1;
        m_ir       = rdata;
        start      = 1'($urandom);
        PCWre      = 1'($urandom);
        imem_ready = 1'b1;
        imem_rdata = $urandom;
        tick();
        start      = 1'b0;
        PCWre      = 1'b0;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
    endtask

    // Monitor: compares every cycle and retires fetches when the DUT signals ir_valid.
    always @(negedge CLK) begin
        if (live) begin
            fetch_t e;
            chk("pc", PC, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc4", PC4, m_pc + 32'd4);
            chk("ir_hold", IR, m_ir);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("imem_req", 32'(imem_req), 32'(m_busy));
            chk("ir_valid", 32'(ir_valid), 32'(m_irv));
            chk("addr_err", 32'(addr_err), 32'(m_err));
            if (imem_req) begin
                if (exp_q.size() == 0) fail_evt("req_without_fetch");
                else chk("req_addr", imem_addr, exp_q[0].addr);
            end
            if (ir_valid) begin
                if (exp_q.size() == 0) fail_evt("ir_valid_without_fetch");
                else begin
                    e = exp_q.pop_front();
                    chk("ir_fetched", IR, e.ir);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST        = 1'b1;
        start      = 1'b0;
        PCWre      = 1'b0;
        PCSrc      = 2'd0;
        imm_ext    = 32'd0;
        jaddr      = 26'd0;
        rs_data    = 32'd0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        do_reset();
        live = 1'b1;
        tick();

        // Minimum-latency fetch from the reset PC.
        fetch(32'h2001_0005, 0, 1'b0, 1'b0);
        chk("ir_first", IR, 32'h2001_0005);

        // Branch backwards then jump.
        commit(2'd3, 32'd0, 26'd0, 32'h0000_0100);
        commit(2'd1, 32'hFFFF_FFFE, 26'd0, 32'd0);
        chk("pc_branch", PC, 32'h0000_00FC);
        commit(2'd2, 32'd0, 26'h0000040, 32'd0);
        chk("pc_jump", PC, 32'h0000_0100);

        // Long stall with ignored start/PCWre.
        fetch(32'hCAFE_F00D, 5, 1'b0, 1'b0);
        chk("pc_after_stall", PC, 32'h0000_0100);

        // Misaligned register target.
        commit(2'd3, 32'd0, 26'd0, 32'h0000_0203);
        tick();
        chk("pc_jr_align", PC, 32'h0000_0200);

        // Wraparound then reset in the middle of a fetch.
        commit(2'd3, 32'd0, 26'd0, 32'hFFFF_FFFC);
        commit(2'd0, 32'd0, 26'd0, 32'd0);
        chk("pc_wrap", PC, 32'h0000_0000);
        commit(2'd3, 32'd0, 26'd0, 32'h0000_0480);
        fetch(32'h1234_5678, 3, 1'b0, 1'b1);
        chk("pc_after_rst", PC, RST_PC);
        tick();

        // start together with PCWre: fetch uses the new PC.
        fetch(32'h0BAD_BEEF, 1, 1'b1, 1'b0);

        for (int n = 0; n < 250; n++) begin
            int r;
            r = int'($urandom % 12);
            if (r < 4) begin
                logic [31:0] rs;
                rs = $urandom;
                if (r == 0) rs = rs & 32'hFFFF_FFFC;
                commit(2'($urandom), $urandom, 26'($urandom), rs);
            end else if (r < 10) begin
                fetch($urandom, int'($urandom % 5), 1'($urandom), 1'b0);
            end else if (r == 10) begin
                fetch($urandom, int'($urandom % 3), 1'b0, 1'b1);
            end else begin
                tick();
            end
        end

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        live = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
